// File: rtl/nibble_serial_adder_pkg.sv
// Shared encodings for the nibble-serial adder and its 4-bit slice.
package nibble_serial_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_adder_csa.sv
// csa_4bit: combinational 4-bit carry-select adder slice.
// The low pair ripples while both upper-pair results are ready for selection.
module csa_4bit
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [2:0] lo;
    logic [2:0] hi0;
    logic [2:0] hi1;

    always_comb begin
        lo   = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
        hi0  = {1'b0, a[3:2]} + {1'b0, b[3:2]};
        hi1  = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
        sum  = {(lo[2] ? hi1[1:0] : hi0[1:0]), lo[1:0]};
        cout = lo[2] ? hi1[2] : hi0[2];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-precision adder: feeds one csa_4bit slice a nibble per cycle, LSB first.
// Optional signed-overflow output enabled by defining NIBBLE_SERIAL_OVF_EN.
//
// state   | meaning
// IDLE    | waiting for operands, in_ready=1
// RUN     | one nibble added per cycle, carry held in carry_q
// DONE    | result presented, held until out_ready
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
`ifdef NIBBLE_SERIAL_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int NIB  = WIDTH / NIB_W;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

    if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;

    logic [NIB_W-1:0]  slice_sum;
    logic              slice_cout;

    csa_4bit u_csa (
        .a    (a_q[NIB_W-1:0]),
        .b    (b_q[NIB_W-1:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

`ifdef NIBBLE_SERIAL_OVF_EN
    logic ovf_q, ovf_d;
    logic c_into_msb;

    // Carry into bit 3 of the top nibble recovered from its sum bit.
    assign c_into_msb = slice_sum[3] ^ a_q[3] ^ b_q[3];
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef NIBBLE_SERIAL_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = op_cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[{idx_q, 2'b00} +: NIB_W] = slice_sum;
                carry_d = slice_cout;
                a_d     = a_q >> NIB_W;
                b_d     = b_q >> NIB_W;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    cout_d  = slice_cout;
`ifdef NIBBLE_SERIAL_OVF_EN
                    ovf_d   = c_into_msb ^ slice_cout;
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef NIBBLE_SERIAL_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
`ifdef NIBBLE_SERIAL_OVF_EN
    assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized self-checking bench for nibble_serial_adder (WIDTH=16) against an arithmetic model.
module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;
`ifdef NIBBLE_SERIAL_OVF_EN
    logic         out_ovf;
`endif

    int checks = 0;
    int errors = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_cin    (op_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
`ifdef NIBBLE_SERIAL_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {ovf, cout, sum} of a + b + cin with plain arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        logic [W:0] s;
        logic       ovf;
        s   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return {ovf, s};
    endfunction

    task automatic check_result(input string tag, input logic [W+1:0] exp);
        check({tag, "_sum"}, {16'h0, out_sum}, {16'h0, exp[W-1:0]});
        check({tag, "_cout"}, {31'h0, out_cout}, {31'h0, exp[W]});
`ifdef NIBBLE_SERIAL_OVF_EN
        check({tag, "_ovf"}, {31'h0, out_ovf}, {31'h0, exp[W+1]});
`endif
    endtask

    // Caller is at a negedge; returns at a negedge with the block back in IDLE.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input int hold, input bit junk);
        logic [W+1:0] exp;
        int lat;
        exp = model(a, b, cin);
        check({tag, "_in_ready"}, {31'h0, in_ready}, 32'd1);
        op_a = a; op_b = b; op_cin = cin; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); op_cin = 1'($urandom);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_latency"}, lat, NIB + 1);
        check_result(tag, exp);
        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                in_valid = 1'b1;
                op_a = W'($urandom); op_b = W'($urandom); op_cin = 1'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_valid"}, {31'h0, out_valid}, 32'd1);
            check({tag, "_hold_in_ready"}, {31'h0, in_ready}, 32'd0);
            check_result({tag, "_hold"}, exp);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, {31'h0, out_valid}, 32'd0);
        check({tag, "_idle_ready"}, {31'h0, in_ready}, 32'd1);
        check({tag, "_idle_busy"}, {31'h0, busy}, 32'd0);
        check({tag, "_idle_sum"}, {16'h0, out_sum}, {16'h0, exp[W-1:0]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W+1:0] expq[$];
        int           acc_t[$];
        logic [W+1:0] e;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; op_cin = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'h0, in_ready}, 32'd1);
        check("rst_out_valid", {31'h0, out_valid}, 32'd0);
        check("rst_out_sum", {16'h0, out_sum}, 32'd0);
        check("rst_out_cout", {31'h0, out_cout}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("d_0009", 16'h0009, 16'h0001, 1'b0, 0, 1'b0);
        run_op("d_ffff", 16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op("d_1234", 16'h1234, 16'h4321, 1'b1, 1, 1'b0);
        run_op("d_7fff", 16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op("d_8000", 16'h8000, 16'h8000, 1'b1, 0, 1'b0);
        run_op("bp", 16'hA5C3, 16'h5A3D, 1'b1, 10, 1'b1);

        for (int n = 0; n < 20; n++) begin
            run_op("rnd", W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        // back-to-back with out_ready tied high
        out_ready = 1'b1; in_valid = 1'b1;
        op_a = W'($urandom); op_b = W'($urandom); op_cin = 1'($urandom);
        for (int c = 0; c < 40; c++) begin
            bit acc;
            acc = 1'b0;
            if (out_valid) begin
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    check_result("tp", e);
                end else begin
                    check("tp_spurious_valid", 32'd1, 32'd0);
                end
            end
            if (in_ready) begin
                acc = 1'b1;
                acc_t.push_back(c);
                expq.push_back(model(op_a, op_b, op_cin));
            end
            @(posedge clk);
            @(negedge clk);
            if (acc) begin
                op_a = W'($urandom); op_b = W'($urandom); op_cin = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid && expq.size() > 0) begin
                e = expq.pop_front();
                check_result("tp_drain", e);
            end
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("tp_outstanding", expq.size(), 32'd0);
        check("tp_accept_count", {31'h0, acc_t.size() >= 6}, 32'd1);
        for (int i = 1; i < acc_t.size(); i++) begin
            check("tp_interval", acc_t[i] - acc_t[i-1], NIB + 2);
        end

        // reset during the second RUN cycle
        op_a = 16'hFFFF; op_b = 16'hFFFF; op_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'h0, out_valid}, 32'd0);
        check("mid_rst_sum", {16'h0, out_sum}, 32'd0);
        check("mid_rst_cout", {31'h0, out_cout}, 32'd0);
        check("mid_rst_busy", {31'h0, busy}, 32'd0);
        check("mid_rst_in_ready", {31'h0, in_ready}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_no_valid", {31'h0, out_valid}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {31'h0, busy}, 32'd0);
        run_op("post_rst", 16'h0091, 16'h0080, 1'b0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-precision adder sequencer wrapped around the team's 4-bit carry-select adder slice.
- Accepts WIDTH-bit operands over a valid/ready handshake and feeds the slice one nibble per cycle, LSB first.
- Registers the slice carry between nibbles, assembles the full sum, and presents sum/carry over a second valid/ready handshake.
- Gives wide additions on a single 4-bit CSA.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, nibble count (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B
- op_cin  input  1  carry-in to nibble 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  sum
- out_cout  output  1  carry out of the top nibble
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, busy=0, nibble index=0, carry reg=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid&in_ready: latch op_a, op_b, op_cin into shift registers, carry reg=op_cin, idx=0, go to RUN.
- RUN: in_ready=0. Each cycle the slice gets a=A[3:0], b=B[3:0], cin=carry reg. Its sum goes into the result register at nibble idx; carry reg takes the slice cout. A and B shift right by 4 and idx increments.
- RUN exit: on the cycle idx==NIB-1, go to DONE.
- DONE: out_valid=1, out_sum/out_cout held stable; both must not change while out_valid=1 and out_ready=0. On out_ready=1, go to IDLE and out_valid drops the next cycle.
- Latency: accept edge to out_valid = NIB+1 cycles (5 for WIDTH=16).
- Throughput: one operation per NIB+2 cycles with out_ready tied high.
- in_ready is combinational from state only (IDLE), never from in_valid. in_valid during RUN/DONE is ignored and the operands are not captured.
- out_sum holds its last value in IDLE.
- Carry ripples across nibbles through the carry reg only; no combinational path from op_* to out_*.
- WIDTH=4: RUN lasts exactly one cycle.
- Reset mid-RUN or mid-DONE: immediate return to reset values. The partial result is discarded and no out_valid pulse occurs.

Optional Feature:
- Macro: NIBBLE_SERIAL_OVF_EN.
- Defined: adds output port out_ovf (1 bit), the two's-complement signed overflow of the full WIDTH-bit add. out_ovf = carry into MSB XOR carry out of MSB, computed in the final RUN cycle, registered with out_sum, reset 0, valid with out_valid.
- Undefined: port absent, no extra logic.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2), nibble width constant 4.
- One sub-module: csa_4bit, the combinational 4-bit carry-select adder slice (a, b, cin -> sum, cout), instantiated once.
- Sequencing, shift registers, and the handshake stay in nibble_serial_adder.

Test Plan:
- WIDTH=16, op_a=16'h0009, op_b=16'h0001, op_cin=0 -> out_sum=16'h000A, out_cout=0; out_valid rises 5 cycles after accept.
- op_a=16'hFFFF, op_b=16'h0001, op_cin=0 -> out_sum=16'h0000, out_cout=1 (carry ripples through all 4 nibbles).
- op_a=16'h1234, op_b=16'h4321, op_cin=1 -> out_sum=16'h5556, out_cout=0. With NIBBLE_SERIAL_OVF_EN, 16'h7FFF+16'h0001 -> out_sum=16'h8000, out_ovf=1, out_cout=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Required: out_valid, out_sum, out_cout stable; in_ready=0; a second in_valid is ignored. Then out_ready=1 -> IDLE and in_ready=1 the next cycle.
- Drop rst_n in the 2nd RUN cycle of 16'hFFFF+16'hFFFF. Required: out_valid=0, out_sum=0, state IDLE immediately; a new add of 16'h0091+16'h0080 after release -> out_sum=16'h0111.
